// File: rtl/wb_pkg.sv
// Shared Wishbone widths and the address-window decode helper used by
// slaves and interconnect decoders alike.
package wb_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_SEL_W  = 4;
  localparam int WB_ADDR_W = 32;

  // Widened to avoid wraparound when base + 4*words reaches the top of the map.
  function automatic logic in_window(input logic [WB_ADDR_W-1:0] addr,
                                     input logic [WB_ADDR_W-1:0] base,
                                     input int unsigned          words);
    logic [WB_ADDR_W+1:0] offset;
    logic [WB_ADDR_W+1:0] limit;
    offset = {2'b00, addr - base};
    limit  = {2'b00, words} << 2;
    return (addr >= base) && (offset < limit);
  endfunction

endpackage

// File: rtl/wb_pipe_delay.sv
// Completion delay line for the pipelined slave: valid bits flush on reset
// or bus-cycle drop, data holds unless a read or error result moves through.
module wb_pipe_delay #(
  parameter int DEPTH = 1,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cyc,
  input  logic         in_valid,
  input  logic         in_err,
  input  logic         in_read,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic         out_err,
  output logic         out_read,
  output logic [W-1:0] out_data
);

  logic         valid_q [DEPTH];
  logic         err_q   [DEPTH];
  logic         read_q  [DEPTH];
  logic [W-1:0] data_q  [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic         prev_valid;
    logic         prev_err;
    logic         prev_read;
    logic [W-1:0] prev_data;

    if (g == 0) begin : g_head
      assign prev_valid = in_valid;
      assign prev_err   = in_err;
      assign prev_read  = in_read;
      assign prev_data  = in_data;
    end else begin : g_tail
      assign prev_valid = valid_q[g-1];
      assign prev_err   = err_q[g-1];
      assign prev_read  = read_q[g-1];
      assign prev_data  = data_q[g-1];
    end

    // Data only advances with a result that drives wb_data_o, so the output
    // keeps its last read value across write acks and idle cycles.
    always_ff @(posedge clk) begin
      if (rst || !cyc) valid_q[g] <= 1'b0;
      else             valid_q[g] <= prev_valid;
      err_q[g]  <= prev_err;
      read_q[g] <= prev_read;
      if (rst)                                  data_q[g] <= '0;
      else if (prev_valid && (prev_read || prev_err)) data_q[g] <= prev_data;
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_err   = err_q[DEPTH-1];
  assign out_read  = read_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/wb_sram_pipe.sv
// Wishbone B4 pipelined single-port SRAM slave with a configurable window,
// depth and read latency; out-of-window requests complete with err.
module wb_sram_pipe
  import wb_pkg::*;
#(
  parameter int unsigned          WORDS     = 'h2000,
  parameter logic [WB_ADDR_W-1:0] BASE_ADDR = 32'h0000_0000,
  parameter int                   LATENCY   = 1,
  parameter string                INIT_FILE = ""
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wb_cyc_i,
  input  logic                 wb_stb_i,
  input  logic                 wb_we_i,
  input  logic [WB_ADDR_W-1:0] wb_addr_i,
  input  logic [WB_DATA_W-1:0] wb_data_i,
  input  logic [WB_SEL_W-1:0]  wb_sel_i,
  output logic                 wb_ack_o,
  output logic                 wb_err_o,
  output logic                 wb_stall_o,
  output logic [WB_DATA_W-1:0] wb_data_o
);

  localparam int IW = $clog2(WORDS);

  logic [WB_DATA_W-1:0] mem [WORDS];

  logic                 accept;
  logic                 in_win;
  logic [WB_ADDR_W-1:0] offset;
  logic [IW-1:0]        idx;

  assign wb_stall_o = rst;
  assign accept     = wb_cyc_i && wb_stb_i && !rst;
  assign in_win     = in_window(wb_addr_i, BASE_ADDR, WORDS);
  assign offset     = wb_addr_i - BASE_ADDR;
  assign idx        = offset[IW+1:2];

  // Byte-enable write port, kept in its own process for block-RAM inference.
  always_ff @(posedge clk) begin
    if (accept && in_win && wb_we_i) begin
      for (int i = 0; i < WB_SEL_W; i++) begin
        if (wb_sel_i[i]) mem[idx][8*i +: 8] <= wb_data_i[8*i +: 8];
      end
    end
  end

  logic                 s0_valid;
  logic                 s0_err;
  logic                 s0_read;
  logic [WB_DATA_W-1:0] s0_data;

  // First result stage doubles as the RAM output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_valid <= 1'b0;
      s0_data  <= '0;
    end else begin
      s0_valid <= accept;
      if (accept && !in_win)        s0_data <= '0;
      else if (accept && !wb_we_i)  s0_data <= mem[idx];
    end
    s0_err  <= !in_win;
    s0_read <= !wb_we_i;
  end

  logic                 out_valid;
  logic                 out_err;
  logic                 out_read;
  logic [WB_DATA_W-1:0] out_data;

  if (LATENCY == 1) begin : g_bypass
    assign out_valid = s0_valid;
    assign out_err   = s0_err;
    assign out_read  = s0_read;
    assign out_data  = s0_data;
  end else begin : g_delay
    wb_pipe_delay #(
      .DEPTH (LATENCY - 1),
      .W     (WB_DATA_W)
    ) u_delay (
      .clk       (clk),
      .rst       (rst),
      .cyc       (wb_cyc_i),
      .in_valid  (s0_valid),
      .in_err    (s0_err),
      .in_read   (s0_read),
      .in_data   (s0_data),
      .out_valid (out_valid),
      .out_err   (out_err),
      .out_read  (out_read),
      .out_data  (out_data)
    );
  end

  assign wb_ack_o  = out_valid && !out_err;
  assign wb_err_o  = out_valid && out_err;
  assign wb_data_o = out_data;

  logic unused_bits;
  assign unused_bits = ^{offset[1:0], offset[WB_ADDR_W-1:IW+2], out_read};

endmodule

// File: tb/tb_wb_sram_pipe.sv
// Directed bench: two slaves (LATENCY 3 and 4, 16 words at 0x1000) on one
// shared request bus, completions logged per slave and checked in order.
module tb_wb_sram_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  sel;

  logic        ack3, err3, stall3;
  logic [31:0] data3;
  logic        ack4, err4, stall4;
  logic [31:0] data4;

  always #5 clk = ~clk;

  wb_sram_pipe #(.WORDS(16), .BASE_ADDR(32'h0000_1000), .LATENCY(3), .INIT_FILE("")) dut_l3 (
    .clk(clk), .rst(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_addr_i(addr), .wb_data_i(wdata), .wb_sel_i(sel),
    .wb_ack_o(ack3), .wb_err_o(err3), .wb_stall_o(stall3), .wb_data_o(data3)
  );

  wb_sram_pipe #(.WORDS(16), .BASE_ADDR(32'h0000_1000), .LATENCY(4), .INIT_FILE("")) dut_l4 (
    .clk(clk), .rst(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_addr_i(addr), .wb_data_i(wdata), .wb_sel_i(sel),
    .wb_ack_o(ack4), .wb_err_o(err4), .wb_stall_o(stall4), .wb_data_o(data4)
  );

  int cycle = 0;
  always @(posedge clk) cycle = cycle + 1;

  typedef struct {
    int          cyc;
    logic        err;
    logic        both;
    logic [31:0] data;
  } cmpl_t;

  cmpl_t q3[$];
  cmpl_t q4[$];

  always @(negedge clk) begin
    if (ack3 || err3) q3.push_back('{cycle, err3, ack3 && err3, data3});
    if (ack4 || err4) q4.push_back('{cycle, err4, ack4 && err4, data4});
  end

  int n_compared   = 0;
  int n_mismatched = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Request is strobed during the cycle numbered acc; completion is due in cycle acc+LATENCY.
  task automatic applyStimulus(input logic c, input logic s, input logic w,
                               input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] bs, output int acc);
    @(negedge clk);
    cyc = c; stb = s; we = w; addr = a; wdata = d; sel = bs;
    acc = cycle;
  endtask

  task automatic idle(input int n);
    int dummy;
    repeat (n) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, dummy);
  endtask

  task automatic checkOutput(input string tag, input int inst, input int acc,
                             input logic exp_err, input logic chk_data,
                             input logic [31:0] exp_data);
    cmpl_t c;
    int    lat;
    logic  present;
    string t;
    lat     = (inst == 0) ? 3 : 4;
    t       = {tag, (inst == 0) ? "@L3" : "@L4"};
    present = (inst == 0) ? (q3.size() != 0) : (q4.size() != 0);
    check({t, "_present"}, 32'(present), 32'd1);
    if (present) begin
      if (inst == 0) c = q3.pop_front();
      else           c = q4.pop_front();
      check({t, "_cycle"}, 32'(c.cyc), 32'(acc + lat));
      check({t, "_err"}, 32'(c.err), 32'(exp_err));
      check({t, "_ackerr_excl"}, 32'(c.both), 32'd0);
      if (chk_data) check({t, "_data"}, c.data, exp_data);
    end
  endtask

  task automatic checkBoth(input string tag, input int acc, input logic exp_err,
                           input logic chk_data, input logic [31:0] exp_data);
    checkOutput(tag, 0, acc, exp_err, chk_data, exp_data);
    checkOutput(tag, 1, acc, exp_err, chk_data, exp_data);
  endtask

  task automatic checkReset(input string tag);
    check({tag, "_stall@L3"}, 32'(stall3), 32'd1);
    check({tag, "_ack@L3"},   32'(ack3),   32'd0);
    check({tag, "_err@L3"},   32'(err3),   32'd0);
    check({tag, "_data@L3"},  data3,       32'd0);
    check({tag, "_stall@L4"}, 32'(stall4), 32'd1);
    check({tag, "_ack@L4"},   32'(ack4),   32'd0);
    check({tag, "_err@L4"},   32'(err4),   32'd0);
    check({tag, "_data@L4"},  data4,       32'd0);
  endtask

  int a1, a2, a3, a4, a5, a6, a7;
  int wacc [8];
  int racc [8];

  initial begin
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    addr = 32'h0; wdata = 32'h0; sel = 4'h0;

    repeat (2) @(negedge clk);
    checkReset("reset");
    rst = 1'b0;

    // Full write then immediate read-back of the same word.
    applyStimulus(1, 1, 1, 32'h1010, 32'hDEADBEEF, 4'hF, a1);
    applyStimulus(1, 1, 0, 32'h1010, 32'h0, 4'h0, a2);
    idle(7);
    checkBoth("wr_full", a1, 1'b0, 1'b0, 32'h0);
    checkBoth("rd_full", a2, 1'b0, 1'b1, 32'hDEADBEEF);

    // Partial lane write over a known background.
    applyStimulus(1, 1, 1, 32'h1014, 32'hAAAAAAAA, 4'hF, a1);
    applyStimulus(1, 1, 1, 32'h1014, 32'h11223344, 4'b0101, a2);
    applyStimulus(1, 1, 0, 32'h1014, 32'h0, 4'h0, a3);
    idle(7);
    checkBoth("wr_bg", a1, 1'b0, 1'b0, 32'h0);
    checkBoth("wr_part", a2, 1'b0, 1'b0, 32'h0);
    checkBoth("rd_part", a3, 1'b0, 1'b1, 32'hAA22AA44);

    // Window edges; the erroring write at 0x1040 would alias word 0 if decoded.
    applyStimulus(1, 1, 1, 32'h1000, 32'h0BADF00D, 4'hF, a1);
    applyStimulus(1, 1, 1, 32'h103C, 32'h12345678, 4'hF, a2);
    applyStimulus(1, 1, 0, 32'h0FFC, 32'h0, 4'h0, a3);
    applyStimulus(1, 1, 0, 32'h1040, 32'h0, 4'h0, a4);
    applyStimulus(1, 1, 1, 32'h1040, 32'hFFFFFFFF, 4'hF, a5);
    applyStimulus(1, 1, 0, 32'h1000, 32'h0, 4'h0, a6);
    applyStimulus(1, 1, 0, 32'h103C, 32'h0, 4'h0, a7);
    idle(7);
    checkBoth("wr_lo", a1, 1'b0, 1'b0, 32'h0);
    checkBoth("wr_hi", a2, 1'b0, 1'b0, 32'h0);
    checkBoth("rd_below", a3, 1'b1, 1'b1, 32'h0);
    checkBoth("rd_above", a4, 1'b1, 1'b1, 32'h0);
    checkBoth("wr_above", a5, 1'b1, 1'b1, 32'h0);
    checkBoth("rd_noalias", a6, 1'b0, 1'b1, 32'h0BADF00D);
    checkBoth("rd_top", a7, 1'b0, 1'b1, 32'h12345678);

    // Back-to-back burst: 8 writes then 8 reads, one completion per cycle.
    for (int i = 0; i < 8; i++)
      applyStimulus(1, 1, 1, 32'h1000 + 32'(4 * i), 32'h100 + 32'(i), 4'hF, wacc[i]);
    for (int i = 0; i < 8; i++)
      applyStimulus(1, 1, 0, 32'h1000 + 32'(4 * i), 32'h0, 4'h0, racc[i]);
    idle(7);
    for (int i = 0; i < 8; i++) checkBoth("burst_wr", wacc[i], 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 8; i++) checkBoth("burst_rd", racc[i], 1'b0, 1'b1, 32'h100 + 32'(i));

    // Abort: the LATENCY 3 slave has already delivered the first read when cyc drops.
    applyStimulus(1, 1, 0, 32'h1000, 32'h0, 4'h0, a1);
    applyStimulus(1, 1, 0, 32'h1004, 32'h0, 4'h0, a2);
    applyStimulus(1, 1, 0, 32'h1008, 32'h0, 4'h0, a3);
    repeat (8) applyStimulus(0, 0, 0, 32'h0, 32'h0, 4'h0, a4);
    checkOutput("abort_first", 0, a1, 1'b0, 1'b1, 32'h100);
    check("abort_rest@L3", 32'(q3.size()), 32'd0);
    check("abort_none@L4", 32'(q4.size()), 32'd0);
    applyStimulus(1, 1, 0, 32'h1008, 32'h0, 4'h0, a5);
    idle(7);
    checkBoth("post_abort", a5, 1'b0, 1'b1, 32'h102);

    // Reset with two reads in flight, then a read on the first cycle out of reset.
    applyStimulus(1, 1, 0, 32'h1000, 32'h0, 4'h0, a1);
    applyStimulus(1, 1, 0, 32'h1004, 32'h0, 4'h0, a2);
    @(negedge clk);
    rst = 1'b1; stb = 1'b0;
    @(negedge clk);
    checkReset("rst_mid1");
    @(negedge clk);
    checkReset("rst_mid2");
    rst = 1'b0; cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 32'h100C;
    a3 = cycle;
    idle(7);
    checkBoth("post_rst", a3, 1'b0, 1'b1, 32'h103);
    check("drained@L3", 32'(q3.size()), 32'd0);
    check("drained@L4", 32'(q4.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
